// File: rtl/core_pkg.sv
// Shared definitions for the RISC core pipeline.
//   - Data and register-index widths.
//   - ALU operation, result-select and forward-select codes.
//   - The ID/EX register layout.
//   - A helper that resolves which pipeline stage, if any, forwards a source register.
package core_pkg;

  localparam int unsigned DataWidth   = 32;
  localparam int unsigned RegIdxWidth = 5;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_W   = 2'b01;
  localparam logic [1:0] FWD_M   = 2'b10;

  typedef struct packed {
    logic                   reg_write;
    logic                   mem_write;
    logic                   jump;
    logic                   branch;
    logic                   alu_src;
    logic [1:0]             result_src;
    logic [2:0]             alu_control;
    logic [DataWidth-1:0]   rd1;
    logic [DataWidth-1:0]   rd2;
    logic [DataWidth-1:0]   imm_ext;
    logic [DataWidth-1:0]   pc;
    logic [DataWidth-1:0]   pc_plus4;
    logic [RegIdxWidth-1:0] rs1;
    logic [RegIdxWidth-1:0] rs2;
    logic [RegIdxWidth-1:0] rd;
  } id_ex_t;

  // The M stage holds the younger result, so it is checked first.
  // Register x0 is hardwired to zero and never forwards.
  function automatic logic [1:0] fwd_select(
    input logic [RegIdxWidth-1:0] rs,
    input logic [RegIdxWidth-1:0] rd_m,
    input logic                   reg_write_m,
    input logic [RegIdxWidth-1:0] rd_w,
    input logic                   reg_write_w
  );
    if (reg_write_m && (rd_m != '0) && (rd_m == rs)) begin
      return FWD_M;
    end else if (reg_write_w && (rd_w != '0) && (rd_w == rs)) begin
      return FWD_W;
    end
    return FWD_REG;
  endfunction

endpackage

// File: rtl/hazard_forward_unit.sv
// Combinational hazard detection and forward selection for the execute stage.
// Ports:
//   rs1_e_i, rs2_e_i      source registers of the instruction in EX
//   rd_e_i, result_src_e_i  destination register and result select of the instruction in EX
//   rs1_d_i, rs2_d_i      source registers of the instruction in decode
//   rd_m_i, reg_write_m_i  destination register and write enable in the M stage
//   rd_w_i, reg_write_w_i  destination register and write enable in the W stage
//   forward_a_o, forward_b_o  operand forward selects (FWD_REG / FWD_W / FWD_M)
//   lw_stall_o            load-use hazard: decode needs a value still being loaded
module hazard_forward_unit
  import core_pkg::*;
(
  input  logic [RegIdxWidth-1:0] rs1_e_i,
  input  logic [RegIdxWidth-1:0] rs2_e_i,
  input  logic [RegIdxWidth-1:0] rd_e_i,
  input  logic [1:0]             result_src_e_i,
  input  logic [RegIdxWidth-1:0] rs1_d_i,
  input  logic [RegIdxWidth-1:0] rs2_d_i,
  input  logic [RegIdxWidth-1:0] rd_m_i,
  input  logic                   reg_write_m_i,
  input  logic [RegIdxWidth-1:0] rd_w_i,
  input  logic                   reg_write_w_i,
  output logic [1:0]             forward_a_o,
  output logic [1:0]             forward_b_o,
  output logic                   lw_stall_o
);

  always_comb begin
    forward_a_o = fwd_select(rs1_e_i, rd_m_i, reg_write_m_i, rd_w_i, reg_write_w_i);
    forward_b_o = fwd_select(rs2_e_i, rd_m_i, reg_write_m_i, rd_w_i, reg_write_w_i);
    lw_stall_o  = (result_src_e_i == RES_MEM) && (rd_e_i != '0) &&
                  ((rs1_d_i == rd_e_i) || (rs2_d_i == rd_e_i));
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage.
//   - Holds the decode-to-execute register.
//   - Inserts a bubble on a flush or on a load-use hazard.
//   - Forwards M/W results into the ALU operands.
// Ports:
//   Inputs:
//     clk, reset                     clock; asynchronous active-high clear
//     *D                             decode-stage data, indices and control
//     ALUResultM, ResultW            forwarding sources
//     RdM, RdW, RegWriteM, RegWriteW  forwarding qualifiers
//     FlushE                         squash the instruction entering EX
//   Outputs:
//     SrcAE, SrcBE, WriteDataE       forwarded operands
//     *E                             registered control and data
//     StallF, StallD                 load-use stall requests
module id_ex_stage
  import core_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DataWidth-1:0]   RD1D,
  input  logic [DataWidth-1:0]   RD2D,
  input  logic [DataWidth-1:0]   ImmExtD,
  input  logic [DataWidth-1:0]   PCD,
  input  logic [DataWidth-1:0]   PCPlus4D,
  input  logic [RegIdxWidth-1:0] Rs1D,
  input  logic [RegIdxWidth-1:0] Rs2D,
  input  logic [RegIdxWidth-1:0] RdD,
  input  logic                   RegWriteD,
  input  logic                   MemWriteD,
  input  logic                   JumpD,
  input  logic                   BranchD,
  input  logic                   ALUSrcD,
  input  logic [1:0]             ResultSrcD,
  input  logic [2:0]             ALUControlD,
  input  logic [DataWidth-1:0]   ALUResultM,
  input  logic [DataWidth-1:0]   ResultW,
  input  logic [RegIdxWidth-1:0] RdM,
  input  logic [RegIdxWidth-1:0] RdW,
  input  logic                   RegWriteM,
  input  logic                   RegWriteW,
  input  logic                   FlushE,
  output logic [DataWidth-1:0]   SrcAE,
  output logic [DataWidth-1:0]   SrcBE,
  output logic [DataWidth-1:0]   WriteDataE,
  output logic [2:0]             ALUControlE,
  output logic                   RegWriteE,
  output logic                   MemWriteE,
  output logic                   JumpE,
  output logic                   BranchE,
  output logic [1:0]             ResultSrcE,
  output logic [DataWidth-1:0]   PCE,
  output logic [DataWidth-1:0]   PCPlus4E,
  output logic [DataWidth-1:0]   ImmExtE,
  output logic [RegIdxWidth-1:0] RdE,
  output logic                   StallF,
  output logic                   StallD
);

  id_ex_t     id_ex_d, id_ex_q;
  logic [1:0] forward_a, forward_b;
  logic       lw_stall;

  hazard_forward_unit u_hazard_forward_unit (
    .rs1_e_i        (id_ex_q.rs1),
    .rs2_e_i        (id_ex_q.rs2),
    .rd_e_i         (id_ex_q.rd),
    .result_src_e_i (id_ex_q.result_src),
    .rs1_d_i        (Rs1D),
    .rs2_d_i        (Rs2D),
    .rd_m_i         (RdM),
    .reg_write_m_i  (RegWriteM),
    .rd_w_i         (RdW),
    .reg_write_w_i  (RegWriteW),
    .forward_a_o    (forward_a),
    .forward_b_o    (forward_b),
    .lw_stall_o     (lw_stall)
  );

  // An all-zero entry is a harmless add into x0, so a bubble is just '0.
  always_comb begin
    id_ex_d = '0;
    if (!(FlushE || lw_stall)) begin
      id_ex_d.reg_write   = RegWriteD;
      id_ex_d.mem_write   = MemWriteD;
      id_ex_d.jump        = JumpD;
      id_ex_d.branch      = BranchD;
      id_ex_d.alu_src     = ALUSrcD;
      id_ex_d.result_src  = ResultSrcD;
      id_ex_d.alu_control = ALUControlD;
      id_ex_d.rd1         = RD1D;
      id_ex_d.rd2         = RD2D;
      id_ex_d.imm_ext     = ImmExtD;
      id_ex_d.pc          = PCD;
      id_ex_d.pc_plus4    = PCPlus4D;
      id_ex_d.rs1         = Rs1D;
      id_ex_d.rs2         = Rs2D;
      id_ex_d.rd          = RdD;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      id_ex_q <= '0;
    end else begin
      id_ex_q <= id_ex_d;
    end
  end

  // Select code 11 is never produced; it falls back to the register value.
  always_comb begin
    SrcAE = id_ex_q.rd1;
    case (forward_a)
      FWD_W:   SrcAE = ResultW;
      FWD_M:   SrcAE = ALUResultM;
      default: SrcAE = id_ex_q.rd1;
    endcase

    WriteDataE = id_ex_q.rd2;
    case (forward_b)
      FWD_W:   WriteDataE = ResultW;
      FWD_M:   WriteDataE = ALUResultM;
      default: WriteDataE = id_ex_q.rd2;
    endcase

    SrcBE = id_ex_q.alu_src ? id_ex_q.imm_ext : WriteDataE;
  end

  assign ALUControlE = id_ex_q.alu_control;
  assign RegWriteE   = id_ex_q.reg_write;
  assign MemWriteE   = id_ex_q.mem_write;
  assign JumpE       = id_ex_q.jump;
  assign BranchE     = id_ex_q.branch;
  assign ResultSrcE  = id_ex_q.result_src;
  assign PCE         = id_ex_q.pc;
  assign PCPlus4E    = id_ex_q.pc_plus4;
  assign ImmExtE     = id_ex_q.imm_ext;
  assign RdE         = id_ex_q.rd;
  assign StallF      = lw_stall;
  assign StallD      = lw_stall;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] RD1D, RD2D, ImmExtD, PCD, PCPlus4D;
  logic [4:0]  Rs1D, Rs2D, RdD;
  logic        RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD;
  logic [1:0]  ResultSrcD;
  logic [2:0]  ALUControlD;
  logic [31:0] ALUResultM, ResultW;
  logic [4:0]  RdM, RdW;
  logic        RegWriteM, RegWriteW, FlushE;
  logic [31:0] SrcAE, SrcBE, WriteDataE;
  logic [2:0]  ALUControlE;
  logic        RegWriteE, MemWriteE, JumpE, BranchE;
  logic [1:0]  ResultSrcE;
  logic [31:0] PCE, PCPlus4E, ImmExtE;
  logic [4:0]  RdE;
  logic        StallF, StallD;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: what the execute stage currently holds.
  logic [31:0] m_rd1, m_rd2, m_imm, m_pc, m_pc4;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic        m_regw, m_memw, m_jump, m_branch, m_alusrc;
  logic [1:0]  m_ressrc;
  logic [2:0]  m_aluc;

  id_ex_stage dut (
    .clk(clk), .reset(reset),
    .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .JumpD(JumpD), .BranchD(BranchD),
    .ALUSrcD(ALUSrcD), .ResultSrcD(ResultSrcD), .ALUControlD(ALUControlD),
    .ALUResultM(ALUResultM), .ResultW(ResultW), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .FlushE(FlushE),
    .SrcAE(SrcAE), .SrcBE(SrcBE), .WriteDataE(WriteDataE), .ALUControlE(ALUControlE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
    .ResultSrcE(ResultSrcE), .PCE(PCE), .PCPlus4E(PCPlus4E), .ImmExtE(ImmExtE),
    .RdE(RdE), .StallF(StallF), .StallD(StallD)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    {m_rd1, m_rd2, m_imm, m_pc, m_pc4} = '0;
    {m_rs1, m_rs2, m_rd} = '0;
    {m_regw, m_memw, m_jump, m_branch, m_alusrc, m_ressrc, m_aluc} = '0;
  endtask

  // Value an operand reads: youngest writer wins, x0 never forwards.
  function automatic logic [31:0] operand(input logic [4:0] rs, input logic [31:0] regval);
    if (rs == 0) return regval;
    if (RegWriteM && RdM == rs) return ALUResultM;
    if (RegWriteW && RdW == rs) return ResultW;
    return regval;
  endfunction

  function automatic logic model_stall();
    return (m_ressrc == 2'b01) && (m_rd != 0) && (Rs1D == m_rd || Rs2D == m_rd);
  endfunction

  task automatic check_all(input string tag);
    logic [31:0] wd;
    wd = operand(m_rs2, m_rd2);
    chk({tag, ".srca"}, SrcAE, operand(m_rs1, m_rd1));
    chk({tag, ".wdata"}, WriteDataE, wd);
    chk({tag, ".srcb"}, SrcBE, m_alusrc ? m_imm : wd);
    chk({tag, ".stall"}, {StallF, StallD}, {2{model_stall()}});
    chk({tag, ".ereg"},
        {ALUControlE, RegWriteE, MemWriteE, JumpE, BranchE, ResultSrcE, PCE, PCPlus4E,
         ImmExtE, RdE},
        {m_aluc, m_regw, m_memw, m_jump, m_branch, m_ressrc, m_pc, m_pc4, m_imm, m_rd});
  endtask

  // One clock edge; the model follows the same capture rule, then inputs may change.
  task automatic tick();
    logic bubble;
    bubble = FlushE || model_stall();
    @(posedge clk);
    if (reset || bubble) begin
      model_clear();
    end else begin
      m_rd1 = RD1D; m_rd2 = RD2D; m_imm = ImmExtD; m_pc = PCD; m_pc4 = PCPlus4D;
      m_rs1 = Rs1D; m_rs2 = Rs2D; m_rd = RdD;
      m_regw = RegWriteD; m_memw = MemWriteD; m_jump = JumpD; m_branch = BranchD;
      m_alusrc = ALUSrcD; m_ressrc = ResultSrcD; m_aluc = ALUControlD;
    end
    #1;
  endtask

  task automatic idle_inputs();
    {RD1D, RD2D, ImmExtD, PCD, PCPlus4D} = '0;
    {Rs1D, Rs2D, RdD} = '0;
    {RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, ResultSrcD, ALUControlD} = '0;
    {ALUResultM, ResultW, RdM, RdW, RegWriteM, RegWriteW, FlushE} = '0;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    model_clear();
    #2;
    check_all("reset");
    tick();
    reset = 1'b0;

    // Asynchronous reset mid-cycle
    RegWriteD = 1; RdD = 5; PCD = 32'h100;
    tick();
    chk("pre_reset_rd", RdE, 5'd5);
    #2;
    reset = 1'b1;
    #1;
    model_clear();
    chk("async_reset_rd", RdE, 5'd0);
    chk("async_reset_regw", RegWriteE, 1'b0);
    chk("async_reset_stall", StallF, 1'b0);
    check_all("async_reset");
    tick();
    reset = 1'b0;

    // Plain pass-through
    idle_inputs();
    RD1D = 7; RD2D = 3; ALUControlD = 3'b001; Rs1D = 1; Rs2D = 2; RdD = 9;
    tick();
    #2;
    chk("pass_srca", SrcAE, 32'd7);
    chk("pass_srcb", SrcBE, 32'd3);
    chk("pass_aluc", ALUControlE, 3'b001);
    check_all("pass");

    // Forwarding priority
    idle_inputs();
    Rs1D = 4; RD1D = 32'h99;
    tick();
    RdM = 4; RegWriteM = 1; ALUResultM = 32'h10; RdW = 4; RegWriteW = 1; ResultW = 32'h20;
    #2;
    chk("fwd_m_wins", SrcAE, 32'h10);
    RegWriteM = 0;
    #1;
    chk("fwd_w", SrcAE, 32'h20);
    RegWriteM = 1; RdM = 0; RdW = 0;
    #1;
    chk("fwd_x0", SrcAE, 32'h99);
    check_all("fwd");

    // Load-use: one bubble, then forwarding from W
    idle_inputs();
    ResultSrcD = 2'b01; RegWriteD = 1; RdD = 6;
    tick();
    idle_inputs();
    Rs2D = 6; RD2D = 32'h55; RdD = 8; RegWriteD = 1;
    #2;
    chk("lu_stallf", StallF, 1'b1);
    chk("lu_stalld", StallD, 1'b1);
    tick();
    #2;
    chk("lu_bubble_regw", RegWriteE, 1'b0);
    chk("lu_bubble_rd", RdE, 5'd0);
    chk("lu_stall_clear", StallF, 1'b0);
    check_all("lu_bubble");
    tick();
    RdW = 6; RegWriteW = 1; ResultW = 32'hABC;
    #2;
    chk("lu_fwd_srcb", SrcBE, 32'hABC);
    check_all("lu_fwd");

    // Flush
    idle_inputs();
    MemWriteD = 1; JumpD = 1; RegWriteD = 1; RdD = 3; FlushE = 1;
    tick();
    FlushE = 0;
    #2;
    chk("flush_ctrl", {MemWriteE, JumpE, RegWriteE}, 3'b000);
    check_all("flush");

    // Flush coinciding with a load-use stall
    idle_inputs();
    ResultSrcD = 2'b01; RegWriteD = 1; RdD = 6;
    tick();
    idle_inputs();
    Rs1D = 6; RdD = 11; RegWriteD = 1; FlushE = 1;
    #2;
    chk("flush_lu_stall", StallD, 1'b1);
    tick();
    FlushE = 0;
    #2;
    chk("flush_lu_bubble", RdE, 5'd0);
    tick();
    #2;
    chk("flush_lu_single", RdE, 5'd11);
    check_all("flush_lu");

    // Immediate operand with rs2 forwarding active
    idle_inputs();
    Rs2D = 7; ALUSrcD = 1; ImmExtD = 32'hFFFF_FFFC; RD2D = 1;
    tick();
    RdM = 7; RegWriteM = 1; ALUResultM = 32'h1234;
    #2;
    chk("imm_srcb", SrcBE, 32'hFFFF_FFFC);
    chk("imm_wdata", WriteDataE, 32'h1234);
    check_all("imm");

    // Randomized traffic over a small register set to provoke hazards
    for (int i = 0; i < 300; i++) begin
      RD1D = $urandom; RD2D = $urandom; ImmExtD = $urandom;
      PCD = $urandom; PCPlus4D = $urandom;
      Rs1D = 5'($urandom_range(0, 7)); Rs2D = 5'($urandom_range(0, 7));
      RdD = 5'($urandom_range(0, 7));
      {RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD} = 5'($urandom);
      ResultSrcD = ($urandom_range(0, 2) == 1) ? 2'b01 : 2'($urandom_range(0, 2));
      ALUControlD = 3'($urandom_range(0, 3));
      ALUResultM = $urandom; ResultW = $urandom;
      RdM = 5'($urandom_range(0, 7)); RdW = 5'($urandom_range(0, 7));
      RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
      FlushE = ($urandom_range(0, 9) == 0);
      #2;
      check_all("rand");
      if ($urandom_range(0, 49) == 0) begin
        reset = 1'b1;
        #1;
        model_clear();
        check_all("rand_reset");
        tick();
        reset = 1'b0;
      end else begin
        tick();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline stage of the RISC core: holds the ID/EX pipeline register and the execute-side operand forwarding. It also detects load-use hazards and inserts bubbles. Its outputs feed the ALU directly (SrcAE, SrcBE, ALUControlE) and carry the remaining control and data on to EX/MEM.

## Interface
- No parameters; data width fixed at 32, register index width fixed at 5.
- clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears the whole register
- RD1D, RD2D  in  32 each  register-file read data from decode
- ImmExtD, PCD, PCPlus4D  in  32 each  immediate, PC and PC+4 from decode
- Rs1D, Rs2D, RdD  in  5 each  source and destination register indices
- RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD  in  1 each  decode control bits
- ResultSrcD  in  2  result select: 00 ALU, 01 memory (load), 10 PC+4
- ALUControlD  in  3  ALU op: 000 add, 001 sub, 010 and, 011 or
- ALUResultM  in  32  memory-stage ALU result, forwarding source
- ResultW  in  32  writeback result, forwarding source
- RdM, RdW  in  5 each  destination registers in M and W
- RegWriteM, RegWriteW  in  1 each  write enables in M and W
- FlushE  in  1  branch/jump taken; squash the instruction entering EX
- SrcAE, SrcBE  out  32 each  ALU operands
- WriteDataE  out  32  forwarded rs2 value for stores
- ALUControlE  out  3  registered ALU op
- RegWriteE, MemWriteE, JumpE, BranchE  out  1 each  registered control
- ResultSrcE  out  2  registered result select
- PCE, PCPlus4E, ImmExtE  out  32 each  registered values
- RdE  out  5  registered destination index
- StallF, StallD  out  1 each  load-use stall request to fetch and decode

## Operation
- **Register contents:** all D-suffixed inputs plus Rs1D and Rs2D, captured into E-side registers each rising edge.
- **Bubble:** on a bubble, every control bit, ALUControlE, ResultSrcE and Rs1E/Rs2E/RdE load 0. Data fields also load 0. The result is a harmless add into x0.
- **Load-use hazard:** lwStall = ResultSrcE==01 && RdE!=0 && (Rs1D==RdE || Rs2D==RdE).
  - StallF = StallD = lwStall, combinational.
- **Bubble insertion:** the register loads a bubble when FlushE || lwStall. Otherwise it loads the decode values.
- **Forwarding for operand A (ForwardAE), computed against Rs1E:**
  - 10 if RegWriteM && RdM!=0 && RdM==Rs1E;
  - else 01 if RegWriteW && RdW!=0 && RdW==Rs1E;
  - else 00.
- **Forwarding for operand B (ForwardBE):** identical rule against Rs2E.
- **Operand muxes:**
  - SrcAE = 00 → RD1E, 01 → ResultW, 10 → ALUResultM. Code 11 is unreachable; drive RD1E.
  - WriteDataE = the same mux driven by ForwardBE over RD2E.
  - SrcBE = ALUSrcE ? ImmExtE : WriteDataE.
- **Boundary cases:**
  - x0 never forwards and never stalls.
  - If M and W both match, M wins.
  - If FlushE and lwStall coincide, a single bubble is inserted.
  - StallF/StallD still assert during that cycle; the decode instruction is re-presented next cycle.

## Timing
- **Reset:** while reset is high, all registered outputs = 0, which equals the bubble. StallF = StallD = 0.
- **Reset mid-operation:** clears immediately regardless of clk; the first post-reset edge captures decode normally.
- **Latency:** one cycle from D inputs to E outputs.
- **Combinational paths:** SrcAE/SrcBE/WriteDataE are combinational from the E register and the M/W forwarding inputs, within the same cycle.
- **Stall timing:** StallF/StallD are combinational from the E register and Rs1D/Rs2D. Exactly one bubble per load-use. Next cycle RdE comes from the bubble (0), so the stall self-clears.
- **Flush timing:** FlushE is sampled at the rising edge; it affects the following cycle's E contents only.

## Structure
- **Shared package `core_pkg`:**
  - ALU op codes ALU_ADD=000, ALU_SUB=001, ALU_AND=010, ALU_OR=011;
  - ResultSrc codes RES_ALU/RES_MEM/RES_PC4;
  - forward select codes FWD_REG=00, FWD_W=01, FWD_M=10;
  - data width 32, register index width 5.
- **Sub-module `hazard_forward_unit`:** purely combinational. It produces ForwardAE, ForwardBE and lwStall. It is reused later when fetch/decode stall logic moves into a dedicated hazard block.
- **Top `id_ex_stage`:** register, bubble muxing and operand muxes.

## Test plan
- **Reset:** assert reset mid-cycle with RegWriteD=1, RdD=5 → all E outputs 0 immediately; StallF=0.
- **Plain pass-through:** RD1D=7, RD2D=3, ALUSrcD=0, ALUControlD=001, no matches → next cycle SrcAE=7, SrcBE=3, ALUControlE=001.
- **Forwarding priority:**
  - Rs1E=4, RdM=4, RegWriteM=1, ALUResultM=0x10, RdW=4, RegWriteW=1, ResultW=0x20 → SrcAE=0x10.
  - Drop RegWriteM → SrcAE=0x20.
  - RdM=RdW=0 → SrcAE=RD1E.
- **Load-use:** E holds a load with RdE=6; decode Rs2D=6 → StallF=StallD=1. Next cycle E is a bubble (RegWriteE=0, RdE=0) and the stall deasserts. The following cycle forwards ResultW into SrcBE.
- **Flush:** FlushE=1 with MemWriteD=1, JumpD=1 → next cycle MemWriteE=0, JumpE=0, RegWriteE=0. FlushE together with lwStall → exactly one bubble.
- **Immediate operand:** ALUSrcD=1, ImmExtD=0xFFFFFFFC, rs2 forwarding active → SrcBE=0xFFFFFFFC, WriteDataE = the forwarded value.
